fetch_unit: RTL and testbench

- Instruction fetch stage: generates the PC, issues word reads to instruction memory, buffers returned words with their PCs.
- Presents instr/pc pairs to the decode stage, which samples them on the clock edge when its rs_read stall is low.
- Handles decode-side stall and branch/jump redirect from execute.
- Sits between the instruction memory port and decode; it is the producer end of the decode instr_in/pc_in_dec interface.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam logic [31:0] FETCH_NOP_INSTR  = 32'h0000_0013;
  localparam int          FETCH_FIFO_DEPTH = 2;
  localparam int          FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FETCH_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // The issue credit scheme should make an overflowing push impossible.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i) begin
      assert (!(push_i && full_o && !do_pop));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, imem request issue, response buffering and redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [31:0] NOP_INSTR  = FETCH_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rs_read_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic [31:0] instr_out_o,
  output logic [31:0] pc_out_o,
  output logic        valid_out_o
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d, last_pc_q, last_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
  logic [CW-1:0] buf_count, pcq_count;
  logic [CW:0]   credit_used;
  logic          buf_full, buf_empty, pcq_full, pcq_empty;
  fetch_entry_t  buf_head, buf_wdata, pcq_head, pcq_wdata;
  logic          accept, resp_keep, buf_push, pop;
  logic          unused_bits;

  // Outstanding requests reserve buffer slots, so a response always finds room.
  assign credit_used      = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid_o = !reset_i && !redirect_valid_i && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o      = fetch_pc_q;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  assign resp_keep = imem_resp_valid_i && (drop_q == '0);
  assign buf_push  = resp_keep && !redirect_valid_i;
  assign pop       = !buf_empty && !rs_read_i && !redirect_valid_i;

  assign buf_wdata = '{instr: imem_resp_data_i, pc: pcq_head.pc};
  assign pcq_wdata = '{instr: 32'h0, pc: fetch_pc_q};

  assign valid_out_o = !buf_empty;
  assign instr_out_o = buf_empty ? NOP_INSTR : buf_head.instr;
  assign pc_out_o    = buf_empty ? last_pc_q : buf_head.pc;

  assign unused_bits = &{1'b0, redirect_pc_i[1:0], buf_full, pcq_full, pcq_empty,
                         pcq_count, pcq_head.instr};

  always_comb begin
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_resp_valid_i);
    drop_d        = drop_q;
    fetch_pc_d    = fetch_pc_q;
    last_pc_d     = pop ? buf_head.pc : last_pc_q;
    if (redirect_valid_i) begin
      // Every response still in flight after this edge belongs to the old path.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      drop_d     = outstanding_d;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_resp_valid_i && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      last_pc_q     <= 32'h0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (redirect_valid_i),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (pop),
    .rdata_o (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_req_pc_q (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (redirect_valid_i),
    .push_i  (accept),
    .wdata_i (pcq_wdata),
    .pop_i   (resp_keep),
    .rdata_o (pcq_head),
    .count_o (pcq_count),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with in-order memory model
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_i, rs_read_i, redirect_valid_i, imem_req_ready_i, imem_resp_valid_i;
  logic [31:0] redirect_pc_i, imem_resp_data_i;
  logic        imem_req_valid_o, valid_out_o;
  logic [31:0] imem_addr_o, instr_out_o, pc_out_o;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .rs_read_i        (rs_read_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i (imem_resp_data_i),
    .instr_out_o      (instr_out_o),
    .pc_out_o         (pc_out_o),
    .valid_out_o      (valid_out_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc, exp_fetch, hold_pc, hold_instr;
  int   out_cnt = 0, pops = 0, first_acc = -1, first_valid = -1;
  bit   after_redir = 0, hold_prev = 0;
  logic s_valid, s_req;
  logic [31:0] s_pc, s_instr, s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, advance the reference model, then drive memory.
  task automatic cycle();
    logic acc, rsp, popv;
    int   due;
    @(negedge clk);
    s_valid = valid_out_o; s_req = imem_req_valid_o; s_pc = pc_out_o;
    s_instr = instr_out_o; s_addr = imem_addr_o;
    if (reset_i) begin
      pend_addr.delete(); pend_due.delete();
      exp_pc = RST_PC; exp_fetch = RST_PC; out_cnt = 0;
      after_redir = 0; hold_prev = 0; first_acc = -1; first_valid = -1;
      check("reset_valid", 32'(s_valid), 32'd0);
      check("reset_req", 32'(s_req), 32'd0);
      check("reset_instr", s_instr, NOP);
    end else begin
      acc  = s_req && imem_req_ready_i;
      rsp  = imem_resp_valid_i;
      popv = s_valid && !rs_read_i && !redirect_valid_i;
      if (!s_valid) check("nop_when_empty", s_instr, NOP);
      if (after_redir) check("valid_after_redirect", 32'(s_valid), 32'd0);
      if (hold_prev) begin
        check("hold_valid", 32'(s_valid), 32'd1);
        check("hold_pc", s_pc, hold_pc);
        check("hold_instr", s_instr, hold_instr);
      end
      if (redirect_valid_i) check("req_in_redirect", 32'(s_req), 32'd0);
      if (acc) begin
        check("fetch_addr", s_addr, exp_fetch);
        acc_log.push_back(s_addr);
        if (first_acc < 0) first_acc = cyc;
        exp_fetch = exp_fetch + 32'd4;
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
        pend_addr.push_back(s_addr);
        pend_due.push_back(due);
      end
      out_cnt = out_cnt + int'(acc) - int'(rsp);
      check("credit_bound", 32'(out_cnt <= DEPTH), 32'd1);
      if (s_valid && first_valid < 0) first_valid = cyc;
      if (popv) begin
        check("pop_pc", s_pc, exp_pc);
        check("pop_instr", s_instr, mem_word(exp_pc));
        pop_log.push_back(s_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      hold_prev   = s_valid && rs_read_i && !redirect_valid_i;
      hold_pc     = s_pc;
      hold_instr  = s_instr;
      after_redir = redirect_valid_i;
      if (redirect_valid_i) begin
        exp_pc    = redirect_pc_i & ~32'h3;
        exp_fetch = exp_pc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, p0, a0;
    logic [31:0] last_pop;
    reset_i = 1'b1; rs_read_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    imem_req_ready_i = 1'b1; imem_resp_valid_i = 1'b0; imem_resp_data_i = 32'h0;
    cycle();
    cycle();
    reset_i = 1'b0;

    // Start-up from RESET_PC with single-cycle memory.
    cycle();
    check("c0_pc_out", s_pc, 32'h0);
    check("c0_req", 32'(s_req), 32'd1);
    check("c0_addr", s_addr, 32'h100);
    cycle();
    cycle();
    check("c2_valid", 32'(s_valid), 32'd1);
    check("c2_pc", s_pc, 32'h100);
    check("c2_instr", s_instr, mem_word(32'h100));
    check("valid_latency", 32'(first_valid - first_acc), 32'd2);

    // Decode stall for five cycles.
    rs_read_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_head_pc", s_pc, 32'h104);
    end
    check("seq_addr0", acc_log[0], 32'h100);
    check("seq_addr1", acc_log[1], 32'h104);
    check("seq_addr2", acc_log[2], 32'h108);
    rs_read_i = 1'b0;
    cycle();
    check("release_pop0", s_pc, 32'h104);

    // Memory not ready for three cycles.
    imem_req_ready_i = 1'b0;
    cycle();
    check("release_pop1", s_pc, 32'h108);
    check("release_pop1_valid", 32'(s_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle();
      check("notready_addr", s_addr, 32'h10C);
      check("notready_req", 32'(s_req), 32'd1);
    end
    check("notready_drained", 32'(s_valid), 32'd0);
    check("notready_no_accept", 32'(acc_log.size()), 32'd3);

    // Redirect with two responses in flight.
    imem_req_ready_i = 1'b1;
    lat_min = 3; lat_max = 3;
    cycle();
    cycle();
    check("pre_redir_acc3", acc_log[3], 32'h10C);
    check("pre_redir_acc4", acc_log[4], 32'h110);
    check("pre_redir_inflight", 32'(pend_addr.size()), 32'd2);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h203;
    cycle();
    redirect_valid_i = 1'b0;
    cycle();
    check("redir_next_addr", s_addr, 32'h200);
    n = 0;
    do begin cycle(); n++; end while (!s_valid && n < 12);
    check("redir_valid_seen", 32'(s_valid), 32'd1);
    check("redir_first_pc", s_pc, 32'h200);

    // Redirect coinciding with a response and a would-be pop.
    lat_min = 1; lat_max = 1;
    n = 0;
    while (!(valid_out_o && imem_resp_valid_i) && n < 20) begin cycle(); n++; end
    check("coincide_found", 32'(valid_out_o && imem_resp_valid_i), 32'd1);
    last_pop = pop_log[$];
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h400;
    cycle();
    redirect_valid_i = 1'b0;
    cycle();
    check("coincide_pc_hold", s_pc, last_pop);
    n = 0;
    while (!s_valid && n < 12) begin cycle(); n++; end
    check("coincide_first_pc", s_pc, 32'h400);

    // Address wrap at the top of the space.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    p0 = pop_log.size();
    a0 = acc_log.size();
    cycle();
    redirect_valid_i = 1'b0;
    n = 0;
    while (pop_log.size() < p0 + 2 && n < 20) begin cycle(); n++; end
    check("wrap_acc0", acc_log[a0], 32'hFFFF_FFFC);
    check("wrap_acc1", acc_log[a0+1], 32'h0000_0000);
    check("wrap_pop0", pop_log[p0], 32'hFFFF_FFFC);
    check("wrap_pop1", pop_log[p0+1], 32'h0000_0000);

    // Randomised traffic, with one reset in the middle.
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      reset_i          = (i == 200);
      rs_read_i        = ($urandom_range(99, 0) < 30);
      imem_req_ready_i = ($urandom_range(99, 0) < 70);
      redirect_valid_i = !reset_i && ($urandom_range(99, 0) < 5);
      redirect_pc_i    = $urandom;
      lat_max          = int'($urandom_range(4, 1));
      cycle();
    end
    reset_i = 1'b0; rs_read_i = 1'b0; redirect_valid_i = 1'b0; imem_req_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    check("random_progress", 32'((pops - p0) >= 40), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
